fifo_uart_tx: RTL



---
 rtl/fifo_uart_tx.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// FIFO read-side drain: pops one byte at a time and shifts it out
// as a UART 8N1 frame in the FIFO read-clock domain.
module fifo_uart_tx #(
  parameter int DSIZE        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int RD_LAT       = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             rempty_i,
  input  logic [DSIZE-1:0] rdata_i,
  output logic             rinc_o,
  output logic             tx_o,
  output logic             busy_o,
  output logic             frame_done_o
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DSIZE > 1) ? $clog2(DSIZE) : 1;
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DSIZE - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [IW-1:0]    bit_q, bit_d;
  logic [LW-1:0]    lat_q, lat_d;
  logic [DSIZE-1:0] shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             rinc_q, rinc_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      lat_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      rinc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      lat_q   <= lat_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      rinc_q  <= rinc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    lat_d   = lat_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    rinc_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (en_i && !rempty_i) begin
          state_d = S_POP;
          rinc_d  = 1'b1;
        end
      end
      S_POP: begin
        state_d = S_WAIT;
        lat_d   = '0;
      end
      // Covers the FIFO read latency after the consuming edge.
      S_WAIT: begin
        if (lat_q == LAT_LAST) begin
          state_d = S_START;
          shreg_d = rdata_i;
          tx_d    = 1'b0;
          baud_d  = '0;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rinc_o       = rinc_q;
  assign tx_o         = tx_q;
  assign busy_o       = (state_q != S_IDLE);
  assign frame_done_o = (state_q == S_STOP) && (baud_q == BAUD_LAST);

endmodule
